x_rams128_arb: RTL and testbench
================================

# x_rams128_arb

Two-requester controller for one 128x1 single-port distributed RAM (synchronous write, asynchronous read). Arbitrates per-cycle access between requesters 0 and 1 with round-robin priority and registers read data. An optional clear sequencer fills the whole array after reset or on command. Sits between two bit-serial clients and a single RAM instance, driving its address, data and write-enable pins.

## Interface
Parameters:
- FILL, 1'b0: value written to every location by the clear sequencer.
- DEPTH, 128: number of RAM locations; fixed at 128 (7-bit address).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ0 / REQ1  in  1  access request; held until GNT seen high.
- WE0 / WE1  in  1  1 = write, 0 = read; held with REQ.
- ADR0 / ADR1  in  7  access address; held with REQ.
- I0 / I1  in  1  write data; held with REQ.
- GNT0 / GNT1  out  1  combinational grant; access completes at the next edge.
- O0 / O1  out  1  registered read data.
- VLD0 / VLD1  out  1  one-cycle pulse: On holds valid read data.
- CLR  in  1  one-cycle pulse requesting a full-array clear.
- BUSY  out  1  clear sequencer active; no grants issued.
- RAM_ADR  out  7  RAM address, shared for read and write.
- RAM_I  out  1  RAM write data.
- RAM_WE  out  1  RAM write enable.
- RAM_O  in  1  RAM asynchronous read data.

## Operation
- States: IDLE, CLEAR. Reset state CLEAR, clear counter CNT = 0 (macro enabled).
- IDLE: at most one access per cycle. Only REQ0 -> GNT0. Only REQ1 -> GNT1. Both -> grant the requester not granted last. Pointer LAST updates on every grant; reset value LAST = 1, so requester 0 wins the first conflict.
- Granted access drives RAM_ADR = ADRn, RAM_I = In, RAM_WE = WEn, all combinational in the grant cycle. With no grant: RAM_WE = 0, RAM_ADR = 0, RAM_I = 0.
- Read grant: On captures RAM_O at the edge ending the grant cycle; VLDn = 1 for the following cycle. The other requester's O is unchanged.
- Write grant: no VLD pulse; On unchanged.
- CLEAR: RAM_WE = 1, RAM_ADR = CNT, RAM_I = FILL, BUSY = 1, GNT0 = GNT1 = 0. CNT increments each edge. On the edge with CNT = 127, state becomes IDLE and CNT becomes 0.
- CLR in IDLE: enter CLEAR at the next edge with CNT = 0. A request that is granted in the same cycle as CLR completes normally. CLR while in CLEAR is ignored and does not restart CNT.
- RST mid-access or mid-clear: all state returns to reset values immediately; the clear restarts from 0.

## Timing
- Reset values: GNT0 = GNT1 = 0, O0 = O1 = 0, VLD0 = VLD1 = 0, BUSY = 1, RAM_WE = 1, RAM_ADR = 0, RAM_I = FILL.
- Clear timing: the first write (address 0) happens at the first edge after RST deasserts. Address 127 is written at the 128th edge. BUSY is low from the 128th edge; the first grant is possible in the following cycle.
- Grant latency: 0 cycles (same cycle as REQ, in IDLE).
- Read data latency: 1 cycle after grant.
- Read-before-write is not possible within one access (single port); reads return contents as of before the grant edge.
- Sustained throughput: one access per cycle in total. With both requesters continuously requesting, grants alternate every cycle.

## Configuration
- X_RAMS128_ARB_CLR_EN defined: clear sequencer, CLR, BUSY and the post-reset fill are present as described.
- Not defined: no CLEAR state; reset state is IDLE; BUSY tied 0; CLR ignored; RAM_WE resets to 0; grants are possible in the first cycle after reset.

## Structure
- Package x_rams128_arb_pkg: state enum (IDLE, CLEAR), DEPTH = 128, ADDR_W = 7.
- Sub-module x_rr_arb2: two-way round-robin arbiter. Inputs: REQ0/REQ1 and an enable (not BUSY). Outputs: GNT0/GNT1. Holds the LAST pointer.
- Top level: clear FSM/counter, RAM-pin mux, and O/VLD registers.

## Test plan
- Reset release with FILL = 1 -> BUSY high for 128 cycles, with RAM_WE = 1 and RAM_ADR stepping 0..127; then reads of addresses 0, 64 and 127 return O = 1.
- Requester 0 writes 1 to address 5, then reads address 5 -> GNT0 same cycle as each request; VLD0 pulses one cycle after the read grant with O0 = 1.
- REQ0 and REQ1 held continuously, reading addresses 3 and 9 -> grant sequence 0,1,0,1; VLD pulses alternate; O1 is unaffected by requester 0's reads.
- CLR pulsed in IDLE while REQ1 is pending -> REQ1 granted that cycle; then 128 cycles of BUSY with GNT low; a second CLR during the clear does not extend BUSY.
- RST asserted at CNT = 60 -> all outputs take their reset values immediately; after release, the clear restarts at address 0.
- Macro undefined -> no BUSY after reset; a read of any address in cycle 1 returns the RAM INIT value.

Source files
------------

// File: rtl/x_rams128_arb_pkg.sv
// Shared types and constants for the 128x1 RAM arbiter.
package x_rams128_arb_pkg;

    localparam int unsigned RAM_DEPTH = 128;
    localparam int unsigned ADDR_W    = 7;

    typedef logic [ADDR_W-1:0] addr_t;

    // Controller state; kept as plain constants for legacy tool flows.
    typedef logic [0:0] state_t;
    localparam state_t StIdle  = 1'b0;
    localparam state_t StClear = 1'b1;

    // Clear counter step with wrap at the last location.
    function automatic addr_t next_addr(input addr_t a, input int unsigned depth);
        if (a == addr_t'(depth - 1)) begin
            return '0;
        end
        return a + addr_t'(1);
    endfunction

endpackage

// File: rtl/x_rr_arb2.sv
// Two-way round-robin arbiter with a one-bit "last granted" pointer.
module x_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic en,
    output logic gnt0,
    output logic gnt1
);

    // 1 = requester 1 was granted last, so requester 0 wins the next conflict.
    logic last;

    // Combinational grant: single requester always wins, conflicts use the pointer.
    always_comb begin
        gnt0 = en & req0 & (~req1 | last);
        gnt1 = en & req1 & (~req0 | ~last);
    end

    // Pointer follows every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (gnt0) begin
            last <= 1'b0;
        end else if (gnt1) begin
            last <= 1'b1;
        end
    end

endmodule

// File: rtl/x_rams128_arb.sv
// Two-requester controller for a 128x1 single-port distributed RAM.
// Optional clear sequencer enabled by defining X_RAMS128_ARB_CLR_EN.
module x_rams128_arb
    import x_rams128_arb_pkg::*;
#(
    parameter logic        FILL  = 1'b0,
    parameter int unsigned DEPTH = 128
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       WE0,
    input  logic       WE1,
    input  logic [6:0] ADR0,
    input  logic [6:0] ADR1,
    input  logic       I0,
    input  logic       I1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       O0,
    output logic       O1,
    output logic       VLD0,
    output logic       VLD1,
    input  logic       CLR,
    output logic       BUSY,
    output logic [6:0] RAM_ADR,
    output logic       RAM_I,
    output logic       RAM_WE,
    input  logic       RAM_O
);

    logic busy;
    logic gnt0;
    logic gnt1;
    logic rd0;
    logic rd1;

`ifdef X_RAMS128_ARB_CLR_EN
    state_t state_q;
    state_t state_d;
    addr_t  cnt_q;
    addr_t  cnt_d;

    // Clear sequencer next state: walk every address once, then return to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (CLR) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            default: begin
                // CLR is ignored here so an in-flight clear is never restarted.
                if (cnt_q == addr_t'(DEPTH - 1)) begin
                    state_d = StIdle;
                end
                cnt_d = next_addr(cnt_q, DEPTH);
            end
        endcase
    end

    // Clear state and counter; reset starts a full fill.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StClear;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StClear);
`else
    // Without the sequencer the array keeps its power-up contents.
    logic unused_cfg;
    assign unused_cfg = ^{FILL, CLR, DEPTH[0]};
    assign busy       = 1'b0;
`endif

    x_rr_arb2 u_arb (
        .clk  (CLK),
        .rst  (RST),
        .req0 (REQ0),
        .req1 (REQ1),
        .en   (~busy),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign GNT0 = gnt0;
    assign GNT1 = gnt1;
    assign BUSY = busy;
    assign rd0  = gnt0 & ~WE0;
    assign rd1  = gnt1 & ~WE1;

    // RAM pin mux: clear writes take precedence, otherwise the granted requester.
    always_comb begin
        RAM_WE  = 1'b0;
        RAM_ADR = '0;
        RAM_I   = 1'b0;
        if (gnt0) begin
            RAM_WE  = WE0;
            RAM_ADR = ADR0;
            RAM_I   = I0;
        end else if (gnt1) begin
            RAM_WE  = WE1;
            RAM_ADR = ADR1;
            RAM_I   = I1;
        end
`ifdef X_RAMS128_ARB_CLR_EN
        if (busy) begin
            RAM_WE  = 1'b1;
            RAM_ADR = cnt_q;
            RAM_I   = FILL;
        end
`endif
    end

    // Read data capture and one-cycle valid pulses per requester.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            O0   <= 1'b0;
            O1   <= 1'b0;
            VLD0 <= 1'b0;
            VLD1 <= 1'b0;
        end else begin
            VLD0 <= rd0;
            VLD1 <= rd1;
            if (rd0) begin
                O0 <= RAM_O;
            end
            if (rd1) begin
                O1 <= RAM_O;
            end
        end
    end

endmodule

// File: tb/tb_x_rams128_arb.sv
// Directed self-checking bench for x_rams128_arb with a behavioural 128x1 RAM.
// Covers both builds, selected by X_RAMS128_ARB_CLR_EN.
module tb_x_rams128_arb;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
    logic [6:0] ADR0 = '0, ADR1 = '0;
    logic       I0 = 1'b0, I1 = 1'b0, CLR = 1'b0;
    logic       GNT0, GNT1, O0, O1, VLD0, VLD1, BUSY;
    logic [6:0] RAM_ADR;
    logic       RAM_I, RAM_WE, RAM_O;

    int n_chk = 0;
    int n_err = 0;

    x_rams128_arb #(.FILL(1'b1), .DEPTH(128)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADR0(ADR0), .ADR1(ADR1), .I0(I0), .I1(I1),
        .GNT0(GNT0), .GNT1(GNT1), .O0(O0), .O1(O1), .VLD0(VLD0), .VLD1(VLD1),
        .CLR(CLR), .BUSY(BUSY),
        .RAM_ADR(RAM_ADR), .RAM_I(RAM_I), .RAM_WE(RAM_WE), .RAM_O(RAM_O)
    );

    always #5 CLK = ~CLK;

    // Single-port distributed RAM: synchronous write, asynchronous read.
    logic mem [128];
    assign RAM_O = mem[RAM_ADR];
    always @(posedge CLK) if (RAM_WE) mem[RAM_ADR] <= RAM_I;

    // Advance to the next cycle start (1 ns after the falling edge).
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic drv0(input logic r, input logic w, input logic [6:0] a, input logic d);
        REQ0 = r; WE0 = w; ADR0 = a; I0 = d;
    endtask

    task automatic drv1(input logic r, input logic w, input logic [6:0] a, input logic d);
        REQ1 = r; WE1 = w; ADR1 = a; I1 = d;
    endtask

`ifdef X_RAMS128_ARB_CLR_EN
    // Reset values, 128-cycle fill with FILL=1, then reads of 0/64/127.
    task automatic test_reset();
        logic [6:0] ra [3];
        ra[0] = 7'd0; ra[1] = 7'd64; ra[2] = 7'd127;
        n_chk++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", BUSY); end
        n_chk++; if (RAM_WE !== 1'b1) begin n_err++; $display("FAIL rst_we: got %b want 1", RAM_WE); end
        n_chk++; if (RAM_ADR !== 7'd0) begin n_err++; $display("FAIL rst_adr: got %0d want 0", RAM_ADR); end
        n_chk++; if (RAM_I !== 1'b1) begin n_err++; $display("FAIL rst_i: got %b want 1", RAM_I); end
        n_chk++;
        if ({GNT0, GNT1, O0, O1, VLD0, VLD1} !== 6'b0) begin
            n_err++; $display("FAIL rst_outs: got %b want 000000", {GNT0, GNT1, O0, O1, VLD0, VLD1});
        end
        RST = 1'b0;
        for (int k = 0; k < 128; k++) begin
            n_chk++;
            if ({BUSY, RAM_WE, RAM_ADR} !== {2'b11, 7'(k)}) begin
                n_err++; $display("FAIL fill[%0d]: got busy=%b we=%b adr=%0d want 1 1 %0d",
                                  k, BUSY, RAM_WE, RAM_ADR, k);
            end
            step();
        end
        n_chk++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL fill_end_busy: got %b want 0", BUSY); end
        for (int i = 0; i < 3; i++) begin
            drv0(1'b1, 1'b0, ra[i], 1'b0);
            #1;
            n_chk++; if (GNT0 !== 1'b1) begin n_err++; $display("FAIL fill_rd_gnt[%0d]: got %b want 1", i, GNT0); end
            step();
            n_chk++;
            if ({VLD0, O0} !== 2'b11) begin
                n_err++; $display("FAIL fill_rd[%0d]: got vld=%b o=%b want 1 1", i, VLD0, O0);
            end
        end
        drv0(1'b0, 1'b0, 7'd0, 1'b0);
        step();
        n_chk++; if (VLD0 !== 1'b0) begin n_err++; $display("FAIL fill_rd_vld_end: got %b want 0", VLD0); end
    endtask

    // CLR with REQ1 pending: REQ1 served, then 128 busy cycles; second CLR ignored.
    task automatic test_clr();
        drv1(1'b1, 1'b0, 7'd3, 1'b0);
        CLR = 1'b1;
        #1;
        n_chk++; if (GNT1 !== 1'b1) begin n_err++; $display("FAIL clr_gnt1: got %b want 1", GNT1); end
        n_chk++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL clr_busy0: got %b want 0", BUSY); end
        step();
        CLR = 1'b0;
        drv1(1'b0, 1'b0, 7'd0, 1'b0);
        drv0(1'b1, 1'b0, 7'd0, 1'b0);
        #1;
        n_chk++;
        if ({VLD1, O1} !== 2'b10) begin
            n_err++; $display("FAIL clr_rd1: got vld=%b o=%b want 1 0", VLD1, O1);
        end
        for (int k = 0; k < 128; k++) begin
            if (k == 10) CLR = 1'b1;
            if (k == 11) CLR = 1'b0;
            #1;
            n_chk++;
            if ({BUSY, GNT0, RAM_ADR} !== {2'b10, 7'(k)}) begin
                n_err++; $display("FAIL clr[%0d]: got busy=%b gnt0=%b adr=%0d want 1 0 %0d",
                                  k, BUSY, GNT0, RAM_ADR, k);
            end
            step();
        end
        #1;
        n_chk++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL clr_end_busy: got %b want 0", BUSY); end
        n_chk++; if (GNT0 !== 1'b1) begin n_err++; $display("FAIL clr_end_gnt0: got %b want 1", GNT0); end
        step();
        drv0(1'b0, 1'b0, 7'd0, 1'b0);
        n_chk++;
        if ({VLD0, O0} !== 2'b11) begin
            n_err++; $display("FAIL clr_end_rd: got vld=%b o=%b want 1 1", VLD0, O0);
        end
        step();
    endtask

    // RST at CNT=60 resets outputs at once; fill restarts from address 0.
    task automatic test_rst_mid_clear();
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        repeat (60) step();
        n_chk++; if (RAM_ADR !== 7'd60) begin n_err++; $display("FAIL mid_adr: got %0d want 60", RAM_ADR); end
        RST = 1'b1;
        #1;
        n_chk++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL mid_rst_busy: got %b want 1", BUSY); end
        n_chk++; if (RAM_ADR !== 7'd0) begin n_err++; $display("FAIL mid_rst_adr: got %0d want 0", RAM_ADR); end
        n_chk++; if (O0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_o0: got %b want 0", O0); end
        step();
        RST = 1'b0;
        #1;
        n_chk++; if (RAM_ADR !== 7'd0) begin n_err++; $display("FAIL mid_rel_adr0: got %0d want 0", RAM_ADR); end
        step();
        n_chk++; if (RAM_ADR !== 7'd1) begin n_err++; $display("FAIL mid_rel_adr1: got %0d want 1", RAM_ADR); end
        repeat (127) step();
        n_chk++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL mid_end_busy: got %b want 0", BUSY); end
    endtask
`else
    // Reset values without the sequencer; reads of initial contents in cycle 1.
    task automatic test_reset();
        logic [6:0] ra [3];
        logic       rv [3];
        ra[0] = 7'd0; ra[1] = 7'd64; ra[2] = 7'd126;
        rv[0] = 1'b1; rv[1] = 1'b0;  rv[2] = 1'b1;
        n_chk++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        n_chk++; if (RAM_WE !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", RAM_WE); end
        n_chk++;
        if ({GNT0, GNT1, O0, O1, VLD0, VLD1} !== 6'b0) begin
            n_err++; $display("FAIL rst_outs: got %b want 000000", {GNT0, GNT1, O0, O1, VLD0, VLD1});
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv0(1'b1, 1'b0, ra[i], 1'b0);
            #1;
            n_chk++; if (GNT0 !== 1'b1) begin n_err++; $display("FAIL init_rd_gnt[%0d]: got %b want 1", i, GNT0); end
            step();
            n_chk++;
            if ({VLD0, O0} !== {1'b1, rv[i]}) begin
                n_err++; $display("FAIL init_rd[%0d]: got vld=%b o=%b want 1 %b", i, VLD0, O0, rv[i]);
            end
        end
        drv0(1'b0, 1'b0, 7'd0, 1'b0);
        step();
    endtask

    // CLR has no effect: no busy period, grants continue.
    task automatic test_clr();
        drv0(1'b1, 1'b0, 7'd126, 1'b0);
        CLR = 1'b1;
        #1;
        n_chk++; if (GNT0 !== 1'b1) begin n_err++; $display("FAIL clr_gnt0: got %b want 1", GNT0); end
        step();
        CLR = 1'b0;
        drv0(1'b1, 1'b0, 7'd64, 1'b0);
        #1;
        n_chk++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL clr_busy: got %b want 0", BUSY); end
        n_chk++; if (GNT0 !== 1'b1) begin n_err++; $display("FAIL clr_gnt0_next: got %b want 1", GNT0); end
        step();
        drv0(1'b0, 1'b0, 7'd0, 1'b0);
        n_chk++; if (O0 !== 1'b0) begin n_err++; $display("FAIL clr_o0: got %b want 0", O0); end
        step();
    endtask

    // RST right after a read: outputs return to reset values immediately.
    task automatic test_rst_mid_clear();
        drv0(1'b1, 1'b0, 7'd0, 1'b0);
        step();
        drv0(1'b0, 1'b0, 7'd0, 1'b0);
        n_chk++; if (O0 !== 1'b1) begin n_err++; $display("FAIL pre_rst_o0: got %b want 1", O0); end
        RST = 1'b1;
        #1;
        n_chk++;
        if ({O0, VLD0, BUSY, RAM_WE} !== 4'b0) begin
            n_err++; $display("FAIL mid_rst: got o0=%b vld0=%b busy=%b we=%b want 0 0 0 0",
                              O0, VLD0, BUSY, RAM_WE);
        end
        step();
        RST = 1'b0;
        #1;
    endtask
`endif

    // Requester 0 write then read of address 5, twice with different data.
    task automatic test_write_read();
        drv0(1'b1, 1'b1, 7'd5, 1'b1);
        #1;
        n_chk++;
        if ({GNT0, RAM_WE, RAM_ADR, RAM_I} !== {2'b11, 7'd5, 1'b1}) begin
            n_err++; $display("FAIL wr_pins: got gnt=%b we=%b adr=%0d i=%b want 1 1 5 1",
                              GNT0, RAM_WE, RAM_ADR, RAM_I);
        end
        step();
        n_chk++; if ({VLD0, O0} !== 2'b01) begin n_err++; $display("FAIL wr_novld: got vld=%b o=%b want 0 1", VLD0, O0); end
        drv0(1'b1, 1'b0, 7'd5, 1'b0);
        #1;
        n_chk++; if ({GNT0, RAM_WE} !== 2'b10) begin n_err++; $display("FAIL rd_pins: got %b want 10", {GNT0, RAM_WE}); end
        step();
        n_chk++; if ({VLD0, O0} !== 2'b11) begin n_err++; $display("FAIL rd5_a: got vld=%b o=%b want 1 1", VLD0, O0); end
        drv0(1'b1, 1'b1, 7'd5, 1'b0);
        step();
        n_chk++; if ({VLD0, O0} !== 2'b01) begin n_err++; $display("FAIL wr0_hold: got vld=%b o=%b want 0 1", VLD0, O0); end
        drv0(1'b1, 1'b0, 7'd5, 1'b0);
        step();
        drv0(1'b0, 1'b0, 7'd0, 1'b0);
        n_chk++; if ({VLD0, O0} !== 2'b10) begin n_err++; $display("FAIL rd5_b: got vld=%b o=%b want 1 0", VLD0, O0); end
        step();
    endtask

    // Both requesters held: grants alternate 0,1,0,1 and O values stay separate.
    task automatic test_back_to_back();
        drv0(1'b1, 1'b1, 7'd3, 1'b0);
        step();
        drv0(1'b0, 1'b0, 7'd0, 1'b0);
        drv1(1'b1, 1'b1, 7'd9, 1'b1);
        #1;
        n_chk++; if (GNT1 !== 1'b1) begin n_err++; $display("FAIL b2b_wr1_gnt: got %b want 1", GNT1); end
        step();
        drv0(1'b1, 1'b0, 7'd3, 1'b0);
        drv1(1'b1, 1'b0, 7'd9, 1'b0);
        #1;
        n_chk++; if ({GNT0, GNT1} !== 2'b10) begin n_err++; $display("FAIL b2b_c1_gnt: got %b want 10", {GNT0, GNT1}); end
        n_chk++; if (RAM_ADR !== 7'd3) begin n_err++; $display("FAIL b2b_c1_adr: got %0d want 3", RAM_ADR); end
        step();
        n_chk++; if ({GNT0, GNT1} !== 2'b01) begin n_err++; $display("FAIL b2b_c2_gnt: got %b want 01", {GNT0, GNT1}); end
        n_chk++;
        if ({VLD0, O0, VLD1} !== 3'b100) begin
            n_err++; $display("FAIL b2b_c2_rd: got vld0=%b o0=%b vld1=%b want 1 0 0", VLD0, O0, VLD1);
        end
        step();
        n_chk++; if ({GNT0, GNT1} !== 2'b10) begin n_err++; $display("FAIL b2b_c3_gnt: got %b want 10", {GNT0, GNT1}); end
        n_chk++;
        if ({VLD1, O1, VLD0} !== 3'b110) begin
            n_err++; $display("FAIL b2b_c3_rd: got vld1=%b o1=%b vld0=%b want 1 1 0", VLD1, O1, VLD0);
        end
        step();
        n_chk++; if ({GNT0, GNT1} !== 2'b01) begin n_err++; $display("FAIL b2b_c4_gnt: got %b want 01", {GNT0, GNT1}); end
        n_chk++;
        if ({VLD0, O0, O1} !== 3'b101) begin
            n_err++; $display("FAIL b2b_c4_rd: got vld0=%b o0=%b o1=%b want 1 0 1", VLD0, O0, O1);
        end
        step();
        drv0(1'b0, 1'b0, 7'd0, 1'b0);
        drv1(1'b0, 1'b0, 7'd0, 1'b0);
        n_chk++; if ({VLD1, VLD0} !== 2'b10) begin n_err++; $display("FAIL b2b_c5_vld: got %b want 10", {VLD1, VLD0}); end
        step();
    endtask

    // After reset the pointer favours requester 0 on the first conflict.
    task automatic test_first_conflict();
        drv0(1'b1, 1'b0, 7'd3, 1'b0);
        drv1(1'b1, 1'b0, 7'd9, 1'b0);
        #1;
        n_chk++; if ({GNT0, GNT1} !== 2'b10) begin n_err++; $display("FAIL conf_first: got %b want 10", {GNT0, GNT1}); end
        step();
        n_chk++; if ({GNT0, GNT1} !== 2'b01) begin n_err++; $display("FAIL conf_second: got %b want 01", {GNT0, GNT1}); end
        drv0(1'b0, 1'b0, 7'd0, 1'b0);
        drv1(1'b0, 1'b0, 7'd0, 1'b0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = ((i % 3) == 0);
        repeat (2) @(negedge CLK);
        #1;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_clr();
        test_rst_mid_clear();
        test_first_conflict();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
